flow_tag_demux: RTL

- Receiving end of the flow-tagged write interface driven by the multi-dataflow accelerator's output port.
- Accepts a single tagged stream (tag in the MSBs, data below, with a write strobe) and steers each word into a per-flow FWFT FIFO.
- Returns per-flow full back-pressure to the producer.
- Exposes independent per-flow read ports, so each flow's consumer (DMA, checker, next stage) drains at its own rate without blocking the other flows.

---
 rtl/flow_tag_demux.sv | 126 ++++++++++++
 1 files changed

// File: rtl/flow_tag_demux.sv
// Tag-steered demultiplexer: one tagged write stream fans out into per-flow FWFT FIFOs,
// each with its own full/empty, read port, accepted-word counter and sticky error flags.
module flow_tag_demux #(
    parameter  int DATA_W = 8,
    parameter  int FLUX   = 2,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 16,
    localparam int TAG_W  = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TAG_W+DATA_W-1:0] in_din,
    input  logic                    in_write,
    output logic [FLUX-1:0]         in_full,
    output logic [FLUX*DATA_W-1:0]  rd_dout,
    output logic [FLUX-1:0]         rd_empty,
    input  logic [FLUX-1:0]         rd_read,
    output logic [FLUX*CNT_W-1:0]   wr_count,
    input  logic [FLUX-1:0]         cnt_clr,
    output logic [FLUX-1:0]         err_ovf,
    output logic [FLUX-1:0]         err_udf,
    output logic                    err_tag
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);

    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              tagBad;
    logic              err_tag_q;

    assign tag     = in_din[TAG_W+DATA_W-1:DATA_W];
    assign data    = in_din[DATA_W-1:0];
    assign tagBad  = ({1'b0, tag} >= (TAG_W+1)'(FLUX));
    assign err_tag = err_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_tag_q <= 1'b0;
        end else if (in_write && tagBad) begin
            err_tag_q <= 1'b1;
        end
    end

    for (genvar f = 0; f < FLUX; f++) begin : g_flow
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wptr_q;
        logic [PTR_W-1:0]  rptr_q;
        logic [PTR_W:0]    occ_q;
        logic [PTR_W:0]    occ_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic              ovf_q;
        logic              udf_q;
        logic              full;
        logic              empty;
        logic              hit;
        logic              wrEn;
        logic              rdEn;

        // Full/empty come only from registered occupancy, so back-pressure never
        // depends combinationally on the producer's strobe.
        assign full  = (occ_q == OCC_FULL);
        assign empty = (occ_q == '0);
        assign hit   = in_write && (tag == TAG_W'(f));
        assign wrEn  = hit && !full;
        assign rdEn  = rd_read[f] && !empty;

        always_comb begin
            occ_d = occ_q;
            if (wrEn && !rdEn) begin
                occ_d = occ_q + 1'b1;
            end else if (!wrEn && rdEn) begin
                occ_d = occ_q - 1'b1;
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr[f]) begin
                cnt_d = wrEn ? CNT_W'(1) : '0;
            end else if (wrEn) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                wptr_q <= '0;
                rptr_q <= '0;
                occ_q  <= '0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                if (wrEn) begin
                    mem_q[wptr_q] <= data;
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (rdEn) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                occ_q <= occ_d;
                cnt_q <= cnt_d;
                if (hit && full) begin
                    ovf_q <= 1'b1;
                end
                if (rd_read[f] && empty) begin
                    udf_q <= 1'b1;
                end
            end
        end

        assign in_full[f]                    = full;
        assign rd_empty[f]                   = empty;
        assign rd_dout[f*DATA_W +: DATA_W]   = mem_q[rptr_q];
        assign wr_count[f*CNT_W +: CNT_W]    = cnt_q;
        assign err_ovf[f]                    = ovf_q;
        assign err_udf[f]                    = udf_q;
    end

endmodule
